// File: rtl/pe_pipe.sv
// Pipelined SMA processing element: shadow/active configuration with explicit commit,
// 1- or 2-stage ALU pipeline with valid tag, and routed/diagonal outputs.
// Optional saturation on ADD/SUB/ACC is enabled by defining PE_PIPE_SAT_EN.
module pe_pipe #(
    parameter int DATA_W = 25,
    parameter int STAGES = 1,
    parameter int CONF_W = 17
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic              IN_VALID,
    input  logic [CONF_W-1:0] CONF_IN,
    input  logic              CONF_WE,
    input  logic              COMMIT,
    input  logic              DL_N_REQ,
    input  logic              DL_NE_REQ,
    input  logic              DL_NW_REQ,
    input  logic [DATA_W-1:0] IN_NORTH,
    input  logic [DATA_W-1:0] IN_SOUTH,
    input  logic [DATA_W-1:0] IN_EAST,
    input  logic [DATA_W-1:0] IN_WEST,
    input  logic [DATA_W-1:0] IN_DL_S,
    input  logic [DATA_W-1:0] IN_DL_SE,
    input  logic [DATA_W-1:0] IN_DL_SW,
    input  logic [DATA_W-1:0] IN_CONST_A,
    input  logic [DATA_W-1:0] IN_CONST_B,
    output logic [DATA_W-1:0] OUT_NORTH,
    output logic [DATA_W-1:0] OUT_SOUTH,
    output logic [DATA_W-1:0] OUT_EAST,
    output logic [DATA_W-1:0] OUT_WEST,
    output logic [DATA_W-1:0] OUT_DL_N,
    output logic [DATA_W-1:0] OUT_DL_NE,
    output logic [DATA_W-1:0] OUT_DL_NW,
    output logic              OUT_VALID,
    output logic              SHADOW_FULL
);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_PASS  = 3'd5;
    localparam logic [2:0] OP_MAX   = 3'd6;
    localparam logic [2:0] OP_ACC   = 3'd7;

    localparam logic [1:0] RT_ZERO  = 2'd0;
    localparam logic [1:0] RT_RES   = 2'd1;
    localparam logic [1:0] RT_BYP   = 2'd2;
    localparam logic [1:0] RT_CONST = 2'd3;

    localparam int SEL_A_LSB = 3;
    localparam int SEL_B_LSB = 6;
    localparam int ROUTE_LSB = 9;

    typedef enum logic {
        CFG_EMPTY = 1'b0,
        CFG_FULL  = 1'b1
    } cfg_state_t;

    cfg_state_t        state_q, state_d;
    logic [CONF_W-1:0] shadow_q, shadow_d;
    logic [CONF_W-1:0] active_q, active_d;
    logic              commit_acc;

    logic [DATA_W-1:0] res_q, res_d;
    logic              valid_q, valid_d;

    // ------------------------------------------------------------------
    // Configuration double buffer (not gated by EN)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= CFG_EMPTY;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        commit_acc = 1'b0;
        case (state_q)
            CFG_EMPTY: begin
                if (CONF_WE) begin
                    shadow_d = CONF_IN;
                    state_d  = CFG_FULL;
                end
            end
            CFG_FULL: begin
                // Simultaneous write and commit: active gets the old shadow word.
                if (COMMIT) begin
                    active_d   = shadow_q;
                    commit_acc = 1'b1;
                    state_d    = CFG_EMPTY;
                end
                if (CONF_WE) begin
                    shadow_d = CONF_IN;
                    state_d  = CFG_FULL;
                end
            end
            default: state_d = CFG_EMPTY;
        endcase
    end

    assign SHADOW_FULL = (state_q == CFG_FULL);

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] a_src [0:7];
    logic [DATA_W-1:0] b_src [0:7];
    logic [DATA_W-1:0] opnd_a, opnd_b;

    always_comb begin
        a_src[0] = IN_SOUTH;
        a_src[1] = IN_EAST;
        a_src[2] = IN_WEST;
        a_src[3] = IN_DL_S;
        a_src[4] = IN_DL_SE;
        a_src[5] = IN_DL_SW;
        a_src[6] = IN_CONST_A;
        a_src[7] = res_q;
        b_src    = a_src;
        b_src[6] = IN_CONST_B;
    end

    assign opnd_a = a_src[active_q[SEL_A_LSB +: 3]];
    assign opnd_b = b_src[active_q[SEL_B_LSB +: 3]];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] alu(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] r
    );
        logic [DATA_W-1:0] y;
`ifdef PE_PIPE_SAT_EN
        logic [DATA_W:0] wide;
        wide = '0;
`endif
        y = '0;
        case (op)
`ifdef PE_PIPE_SAT_EN
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                y    = wide[DATA_W] ? '1 : wide[DATA_W-1:0];
            end
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                y    = wide[DATA_W] ? '0 : wide[DATA_W-1:0];
            end
            OP_ACC: begin
                wide = {1'b0, r} + {1'b0, a};
                y    = wide[DATA_W] ? '1 : wide[DATA_W-1:0];
            end
`else
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_ACC:  y = r + a;
`endif
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_PASS: y = a;
            OP_MAX:  y = (a > b) ? a : b;
            default: y = '0;
        endcase
        return y;
    endfunction

    // ------------------------------------------------------------------
    // Pipeline front end: either direct (1 stage) or registered (2 stages)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] fin_a, fin_b, fin_r;
    logic [2:0]        fin_op;
    logic              fin_v;

    generate
        if (STAGES == 2) begin : g_two_stage
            logic [DATA_W-1:0] s1_a_q, s1_a_d;
            logic [DATA_W-1:0] s1_b_q, s1_b_d;
            logic [DATA_W-1:0] s1_r_q, s1_r_d;
            logic [2:0]        s1_op_q, s1_op_d;
            logic              s1_v_q, s1_v_d;

            // RES is sampled at launch, so ACC/FB see the value current at issue.
            always_comb begin
                s1_a_d  = s1_a_q;
                s1_b_d  = s1_b_q;
                s1_r_d  = s1_r_q;
                s1_op_d = s1_op_q;
                s1_v_d  = s1_v_q;
                if (EN) begin
                    s1_a_d  = opnd_a;
                    s1_b_d  = opnd_b;
                    s1_r_d  = res_q;
                    s1_op_d = active_q[2:0];
                    s1_v_d  = IN_VALID;
                end
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    s1_a_q  <= '0;
                    s1_b_q  <= '0;
                    s1_r_q  <= '0;
                    s1_op_q <= '0;
                    s1_v_q  <= 1'b0;
                end else begin
                    s1_a_q  <= s1_a_d;
                    s1_b_q  <= s1_b_d;
                    s1_r_q  <= s1_r_d;
                    s1_op_q <= s1_op_d;
                    s1_v_q  <= s1_v_d;
                end
            end

            assign fin_a  = s1_a_q;
            assign fin_b  = s1_b_q;
            assign fin_r  = s1_r_q;
            assign fin_op = s1_op_q;
            assign fin_v  = s1_v_q;
        end else begin : g_one_stage
            assign fin_a  = opnd_a;
            assign fin_b  = opnd_b;
            assign fin_r  = res_q;
            assign fin_op = active_q[2:0];
            assign fin_v  = IN_VALID;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Result register
    // ------------------------------------------------------------------
    always_comb begin
        res_d   = res_q;
        valid_d = valid_q;
        if (EN) begin
            valid_d = fin_v;
            if (fin_v) begin
                res_d = alu(fin_op, fin_a, fin_b, fin_r);
            end
        end
        if (commit_acc) begin
            res_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign OUT_VALID = valid_q;

    // ------------------------------------------------------------------
    // Routed outputs, index order N, S, E, W
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] byp_src   [0:3];
    logic [DATA_W-1:0] route_out [0:3];

    assign byp_src[0] = IN_SOUTH;
    assign byp_src[1] = IN_NORTH;
    assign byp_src[2] = IN_WEST;
    assign byp_src[3] = IN_EAST;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_route
            always_comb begin
                route_out[gi] = '0;
                case (active_q[ROUTE_LSB + 2*gi +: 2])
                    RT_ZERO:  route_out[gi] = '0;
                    RT_RES:   route_out[gi] = res_q;
                    RT_BYP:   route_out[gi] = byp_src[gi];
                    RT_CONST: route_out[gi] = IN_CONST_A;
                    default:  route_out[gi] = '0;
                endcase
            end
        end
    endgenerate

    assign OUT_NORTH = route_out[0];
    assign OUT_SOUTH = route_out[1];
    assign OUT_EAST  = route_out[2];
    assign OUT_WEST  = route_out[3];

    assign OUT_DL_N  = DL_N_REQ  ? res_q : '0;
    assign OUT_DL_NE = DL_NE_REQ ? res_q : '0;
    assign OUT_DL_NW = DL_NW_REQ ? res_q : '0;

endmodule

// File: tb/tb_pe_pipe.sv
// Directed self-checking bench for pe_pipe built with a two-stage pipeline;
// expected values are hand-computed constants.
module tb_pe_pipe;

    localparam int DW = 25;
    localparam int ST = 2;
    localparam int CW = 17;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          EN;
    logic          IN_VALID;
    logic [CW-1:0] CONF_IN;
    logic          CONF_WE;
    logic          COMMIT;
    logic          DL_N_REQ, DL_NE_REQ, DL_NW_REQ;
    logic [DW-1:0] IN_NORTH, IN_SOUTH, IN_EAST, IN_WEST;
    logic [DW-1:0] IN_DL_S, IN_DL_SE, IN_DL_SW, IN_CONST_A, IN_CONST_B;
    logic [DW-1:0] OUT_NORTH, OUT_SOUTH, OUT_EAST, OUT_WEST;
    logic [DW-1:0] OUT_DL_N, OUT_DL_NE, OUT_DL_NW;
    logic          OUT_VALID;
    logic          SHADOW_FULL;

    int n_cmp = 0;
    int n_err = 0;

    pe_pipe #(.DATA_W(DW), .STAGES(ST), .CONF_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .IN_VALID(IN_VALID),
        .CONF_IN(CONF_IN), .CONF_WE(CONF_WE), .COMMIT(COMMIT),
        .DL_N_REQ(DL_N_REQ), .DL_NE_REQ(DL_NE_REQ), .DL_NW_REQ(DL_NW_REQ),
        .IN_NORTH(IN_NORTH), .IN_SOUTH(IN_SOUTH), .IN_EAST(IN_EAST), .IN_WEST(IN_WEST),
        .IN_DL_S(IN_DL_S), .IN_DL_SE(IN_DL_SE), .IN_DL_SW(IN_DL_SW),
        .IN_CONST_A(IN_CONST_A), .IN_CONST_B(IN_CONST_B),
        .OUT_NORTH(OUT_NORTH), .OUT_SOUTH(OUT_SOUTH), .OUT_EAST(OUT_EAST), .OUT_WEST(OUT_WEST),
        .OUT_DL_N(OUT_DL_N), .OUT_DL_NE(OUT_DL_NE), .OUT_DL_NW(OUT_DL_NW),
        .OUT_VALID(OUT_VALID), .SHADOW_FULL(SHADOW_FULL)
    );

    always #5 CLK = ~CLK;

    function automatic logic [CW-1:0] cfg(input logic [2:0] op, input logic [2:0] sa,
                                          input logic [2:0] sb, input logic [1:0] rn,
                                          input logic [1:0] rs, input logic [1:0] re,
                                          input logic [1:0] rw);
        return {rw, re, rs, rn, sb, sa, op};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_cfg(input logic [CW-1:0] w);
        CONF_IN = w;
        CONF_WE = 1'b1;
        tick();
        CONF_WE = 1'b0;
        COMMIT  = 1'b1;
        tick();
        COMMIT  = 1'b0;
    endtask

    task automatic launch_one();
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
    endtask

    // op, const_a, const_b, expected result
    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
        string         tag;
    } alu_vec_t;

    alu_vec_t vecs [7];

    initial begin
        vecs[0] = '{3'd0, 25'h1234567, 25'h0ABCDEF, 25'h1CF1356, "add"};
        vecs[2] = '{3'd2, 25'h1234567, 25'h0ABCDEF, 25'h0234567, "and"};
        vecs[3] = '{3'd3, 25'h1234567, 25'h0ABCDEF, 25'h1ABCDEF, "or"};
        vecs[4] = '{3'd4, 25'h1234567, 25'h0ABCDEF, 25'h1888888, "xor"};
        vecs[5] = '{3'd6, 25'h0ABCDEF, 25'h1234567, 25'h1234567, "max"};
`ifdef PE_PIPE_SAT_EN
        vecs[1] = '{3'd1, 25'd2, 25'd3, 25'h0000000, "sub_2_3"};
        vecs[6] = '{3'd0, 25'h1FFFFFF, 25'd2, 25'h1FFFFFF, "add_ovf"};
`else
        vecs[1] = '{3'd1, 25'd2, 25'd3, 25'h1FFFFFF, "sub_2_3"};
        vecs[6] = '{3'd0, 25'h1FFFFFF, 25'd2, 25'h0000001, "add_ovf"};
`endif

        RST_N = 1'b0; EN = 1'b1; IN_VALID = 1'b0;
        CONF_IN = '0; CONF_WE = 1'b0; COMMIT = 1'b0;
        DL_N_REQ = 1'b1; DL_NE_REQ = 1'b1; DL_NW_REQ = 1'b1;
        IN_NORTH = 25'h101; IN_SOUTH = 25'h202; IN_EAST = 25'h303; IN_WEST = 25'h404;
        IN_DL_S = '0; IN_DL_SE = '0; IN_DL_SW = '0; IN_CONST_A = 25'h505; IN_CONST_B = '0;

        // Reset state
        #12;
        chk("rst_north", OUT_NORTH, '0);
        chk("rst_south", OUT_SOUTH, '0);
        chk("rst_east",  OUT_EAST,  '0);
        chk("rst_west",  OUT_WEST,  '0);
        chk("rst_dl_n",  OUT_DL_N,  '0);
        chk("rst_dl_ne", OUT_DL_NE, '0);
        chk("rst_dl_nw", OUT_DL_NW, '0);
        chk("rst_valid", DW'(OUT_VALID), '0);
        chk("rst_shadow", DW'(SHADOW_FULL), '0);
        tick();
        RST_N = 1'b1;
        DL_N_REQ = 1'b0; DL_NE_REQ = 1'b0; DL_NW_REQ = 1'b0;
        tick();

        // ADD SOUTH+EAST, route N=RES
        CONF_IN = cfg(3'd0, 3'd0, 3'd1, 2'd1, 2'd0, 2'd0, 2'd0);
        CONF_WE = 1'b1;
        tick();
        CONF_WE = 1'b0;
        chk("shadow_wr", DW'(SHADOW_FULL), 25'd1);
        COMMIT = 1'b1;
        tick();
        COMMIT = 1'b0;
        chk("shadow_cmt", DW'(SHADOW_FULL), '0);
        IN_SOUTH = 25'd3; IN_EAST = 25'd4; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        chk("lat_early_v", DW'(OUT_VALID), '0);
        tick();
        chk("add_valid", DW'(OUT_VALID), 25'd1);
        chk("add_north", OUT_NORTH, 25'd7);
        tick();
        chk("bubble_v", DW'(OUT_VALID), '0);
        chk("bubble_hold", OUT_NORTH, 25'd7);

        // ACC with CONST_A=5, issued every STAGES cycles
        load_cfg(cfg(3'd7, 3'd6, 3'd0, 2'd1, 2'd0, 2'd0, 2'd0));
        chk("acc_cleared", OUT_NORTH, '0);
        IN_CONST_A = 25'd5;
        for (int k = 1; k <= 4; k++) begin
            IN_VALID = 1'b1;
            if (k == 4) CONF_WE = 1'b1;
            tick();
            IN_VALID = 1'b0;
            CONF_WE  = 1'b0;
            tick();
            chk($sformatf("acc_%0d", k), OUT_NORTH, DW'(5 * k));
            chk($sformatf("acc_v_%0d", k), DW'(OUT_VALID), 25'd1);
        end
        COMMIT = 1'b1;
        tick();
        COMMIT = 1'b0;
        chk("acc_commit", OUT_NORTH, '0);
        chk("acc_cmt_v", DW'(OUT_VALID), '0);

        // ALU op table, operands from CONST_A/CONST_B
        for (int i = 0; i < 7; i++) begin
            load_cfg(cfg(vecs[i].op, 3'd6, 3'd6, 2'd1, 2'd0, 2'd0, 2'd0));
            IN_CONST_A = vecs[i].a;
            IN_CONST_B = vecs[i].b;
            launch_one();
            chk(vecs[i].tag, OUT_NORTH, vecs[i].exp);
        end

        // Simultaneous write+commit while FULL; X: PASS_A N=RES, Y: PASS_A N=CONST S=RES
        IN_CONST_A = 25'h55;
        CONF_IN = cfg(3'd5, 3'd6, 3'd0, 2'd1, 2'd0, 2'd0, 2'd0);
        CONF_WE = 1'b1;
        tick();
        chk("x_full", DW'(SHADOW_FULL), 25'd1);
        CONF_IN = cfg(3'd5, 3'd6, 3'd0, 2'd3, 2'd1, 2'd0, 2'd0);
        COMMIT = 1'b1;
        tick();
        CONF_WE = 1'b0;
        COMMIT  = 1'b0;
        chk("wc_full", DW'(SHADOW_FULL), 25'd1);
        chk("wc_active_x", OUT_NORTH, '0);
        launch_one();
        chk("wc_pass", OUT_NORTH, 25'h55);
        COMMIT = 1'b1;
        tick();
        COMMIT = 1'b0;
        chk("y_empty", DW'(SHADOW_FULL), '0);
        chk("y_north_c", OUT_NORTH, 25'h55);
        chk("y_south_clr", OUT_SOUTH, '0);
        launch_one();
        chk("y_south", OUT_SOUTH, 25'h55);
        COMMIT = 1'b1;
        tick();
        COMMIT = 1'b0;
        chk("ign_cmt_res", OUT_SOUTH, 25'h55);
        chk("ign_cmt_sf", DW'(SHADOW_FULL), '0);

        // Diagonal gating with RES=9
        IN_CONST_A = 25'd9;
        launch_one();
        DL_NE_REQ = 1'b1;
        #1;
        chk("dl_ne", OUT_DL_NE, 25'd9);
        chk("dl_n_off", OUT_DL_N, '0);
        chk("dl_nw_off", OUT_DL_NW, '0);
        DL_N_REQ = 1'b1;
        #1;
        chk("dl_n_on", OUT_DL_N, 25'd9);
        DL_N_REQ = 1'b0; DL_NE_REQ = 1'b0;

        // Route W=bypass from IN_EAST, E=zero
        load_cfg(cfg(3'd5, 3'd6, 3'd0, 2'd0, 2'd0, 2'd0, 2'd2));
        IN_EAST = 25'h11; IN_WEST = 25'h33;
        #1;
        chk("byp_w_11", OUT_WEST, 25'h11);
        IN_EAST = 25'h22;
        #1;
        chk("byp_w_22", OUT_WEST, 25'h22);
        chk("route_e0", OUT_EAST, '0);

        // EN freeze mid-stream; PASS_A from SOUTH, N=RES
        load_cfg(cfg(3'd5, 3'd0, 3'd0, 2'd1, 2'd0, 2'd0, 2'd0));
        IN_SOUTH = 25'd10; IN_VALID = 1'b1;
        tick();
        IN_SOUTH = 25'd20;
        tick();
        chk("en_pre", OUT_NORTH, 25'd10);
        EN = 1'b0;
        IN_SOUTH = 25'd30;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("en_hold_%0d", c), OUT_NORTH, 25'd10);
            chk($sformatf("en_hold_v%0d", c), DW'(OUT_VALID), 25'd1);
        end
        EN = 1'b1;
        tick();
        chk("en_res_20", OUT_NORTH, 25'd20);
        IN_VALID = 1'b0;
        tick();
        chk("en_res_30", OUT_NORTH, 25'd30);
        chk("en_v_30", DW'(OUT_VALID), 25'd1);
        tick();
        chk("en_tail_v", DW'(OUT_VALID), '0);
        chk("en_tail_res", OUT_NORTH, 25'd30);

        // Asynchronous reset mid-stream with a pending shadow word
        IN_SOUTH = 25'd40; IN_VALID = 1'b1;
        tick();
        tick();
        chk("pre_rst", OUT_NORTH, 25'd40);
        CONF_IN = cfg(3'd5, 3'd0, 3'd0, 2'd1, 2'd2, 2'd2, 2'd2);
        CONF_WE = 1'b1;
        tick();
        CONF_WE = 1'b0;
        chk("pre_rst_sf", DW'(SHADOW_FULL), 25'd1);
        DL_NE_REQ = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_north", OUT_NORTH, '0);
        chk("arst_valid", DW'(OUT_VALID), '0);
        chk("arst_sf", DW'(SHADOW_FULL), '0);
        chk("arst_dl_ne", OUT_DL_NE, '0);
        chk("arst_west", OUT_WEST, '0);
        tick();
        RST_N = 1'b1;
        IN_VALID = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
